// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC front-panel time-set controller.
package rtc_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_SET_HH,
        ST_SET_MM,
        ST_SET_SS,
        ST_COMMIT
    } state_t;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HH   = 2'd1;
    localparam logic [1:0] FIELD_MM   = 2'd2;
    localparam logic [1:0] FIELD_SS   = 2'd3;

    localparam logic [5:0] MAX_HOUR    = 6'd23;
    localparam logic [5:0] MAX_MIN_SEC = 6'd59;

    // Out-of-range values fold to 0 on increment and to max on decrement.
    function automatic logic [5:0] step_field(
        input logic [5:0] v,
        input logic [5:0] max,
        input logic       up
    );
        logic [5:0] r;
        if (up) r = (v >= max) ? 6'd0 : v + 6'd1;
        else    r = (v == 6'd0 || v > max) ? max : v - 6'd1;
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low pushbutton: 2-flop sync, debounce counter, press pulse and
// optional hold-to-repeat.
module key_debounce
    import rtc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_event
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    logic          r_s1, r_s2, r_deb, r_first, r_event;
    logic [DW-1:0] r_db_cnt;
    logic [RW-1:0] r_rp_cnt;
    logic          w_settle, w_press, w_repeat;
    logic [RW-1:0] w_rp_lim;

    assign w_settle = (r_s2 != r_deb) && (r_db_cnt == DB_LAST);
    assign w_press  = w_settle && !r_s2;
    assign w_rp_lim = r_first ? RD_LAST : RP_LAST;
    assign w_repeat = REPEAT_EN && !r_deb && (r_rp_cnt == w_rp_lim);
    assign o_event  = r_event;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1     <= 1'b1;
            r_s2     <= 1'b1;
            r_deb    <= 1'b1;
            r_db_cnt <= '0;
            r_rp_cnt <= '0;
            r_first  <= 1'b1;
            r_event  <= 1'b0;
        end else begin
            r_s1 <= i_key_n;
            r_s2 <= r_s1;
            if (r_s2 == r_deb) begin
                r_db_cnt <= '0;
            end else if (w_settle) begin
                r_deb    <= r_s2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
            // Hold timer runs only while the debounced level is low.
            if (w_press || r_deb) begin
                r_rp_cnt <= '0;
                r_first  <= 1'b1;
            end else if (w_repeat) begin
                r_rp_cnt <= '0;
                r_first  <= 1'b0;
            end else begin
                r_rp_cnt <= r_rp_cnt + 1'b1;
            end
            r_event <= w_press || w_repeat;
        end
    end

endmodule

// File: rtl/rtc_time_set_controller.sv
// Front-panel set-mode controller: edits HH:MM:SS shadows and issues a
// one-cycle load to the clock counters on commit.
module rtc_time_set_controller
    import rtc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000,
    parameter int BLINK_HALF      = 12_500_000,
    parameter int TIMEOUT         = 500_000_000
) (
    input  logic       clk_50MHz,
    input  logic       rst,
    input  logic       key_mode_n,
    input  logic       key_inc_n,
    input  logic       key_dec_n,
    input  logic [5:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic       load_strobe,
    output logic [5:0] load_hour,
    output logic [5:0] load_min,
    output logic [5:0] load_sec,
    output logic       set_active,
    output logic [1:0] field_sel,
    output logic       blink,
    output logic [5:0] disp_hour,
    output logic [5:0] disp_min,
    output logic [5:0] disp_sec
);

    localparam int TW = $clog2(TIMEOUT);
    localparam int BW = $clog2(BLINK_HALF);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    logic w_ev_mode, w_ev_inc, w_ev_dec;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b0),
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_mode (.clk(clk_50MHz), .rst(rst), .i_key_n(key_mode_n), .o_event(w_ev_mode));

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b1),
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_inc (.clk(clk_50MHz), .rst(rst), .i_key_n(key_inc_n), .o_event(w_ev_inc));

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b1),
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_dec (.clk(clk_50MHz), .rst(rst), .i_key_n(key_dec_n), .o_event(w_ev_dec));

    state_t        r_state, w_next;
    logic [5:0]    r_hour, r_min, r_sec;
    logic [TW-1:0] r_tmo;
    logic [BW-1:0] r_bcnt;
    logic          r_blink;
    logic          w_in_set, w_any_ev, w_inc_ok, w_dec_ok, w_edit, w_timeout;

    assign w_in_set  = (r_state == ST_SET_HH) || (r_state == ST_SET_MM) ||
                       (r_state == ST_SET_SS);
    assign w_any_ev  = w_ev_mode || w_ev_inc || w_ev_dec;
    // Mode beats an adjustment; inc together with dec cancels out.
    assign w_inc_ok  = w_ev_inc && !w_ev_dec && !w_ev_mode;
    assign w_dec_ok  = w_ev_dec && !w_ev_inc && !w_ev_mode;
    assign w_edit    = w_in_set && (w_inc_ok || w_dec_ok);
    assign w_timeout = w_in_set && !w_any_ev && (r_tmo == TMO_LAST);

    always_ff @(posedge clk_50MHz) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_RUN:    if (w_ev_mode) w_next = ST_SET_HH;
            ST_SET_HH: if (w_ev_mode) w_next = ST_SET_MM;
                       else if (w_timeout) w_next = ST_RUN;
            ST_SET_MM: if (w_ev_mode) w_next = ST_SET_SS;
                       else if (w_timeout) w_next = ST_RUN;
            ST_SET_SS: if (w_ev_mode) w_next = ST_COMMIT;
                       else if (w_timeout) w_next = ST_RUN;
            ST_COMMIT: w_next = ST_RUN;
            default:   w_next = ST_RUN;
        endcase
    end

    always_comb begin
        field_sel   = FIELD_NONE;
        load_strobe = 1'b0;
        unique case (r_state)
            ST_SET_HH: field_sel   = FIELD_HH;
            ST_SET_MM: field_sel   = FIELD_MM;
            ST_SET_SS: field_sel   = FIELD_SS;
            ST_COMMIT: load_strobe = 1'b1;
            default:   ;
        endcase
    end

    assign set_active = (field_sel != FIELD_NONE);

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            r_hour <= '0;
            r_min  <= '0;
            r_sec  <= '0;
        end else if (r_state == ST_RUN) begin
            r_hour <= cur_hour;
            r_min  <= cur_min;
            r_sec  <= cur_sec;
        end else if (w_edit) begin
            unique case (r_state)
                ST_SET_HH: r_hour <= step_field(r_hour, MAX_HOUR, w_inc_ok);
                ST_SET_MM: r_min  <= step_field(r_min, MAX_MIN_SEC, w_inc_ok);
                ST_SET_SS: r_sec  <= step_field(r_sec, MAX_MIN_SEC, w_inc_ok);
                default:   ;
            endcase
        end
    end

    // Any state change or edit restarts blink in the visible phase.
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            r_tmo   <= '0;
            r_bcnt  <= '0;
            r_blink <= 1'b1;
        end else begin
            if (!w_in_set || w_any_ev || (w_next != r_state)) r_tmo <= '0;
            else                                              r_tmo <= r_tmo + 1'b1;
            if (!w_in_set || w_edit || (w_next != r_state)) begin
                r_bcnt  <= '0;
                r_blink <= 1'b1;
            end else if (r_bcnt == BLINK_LAST) begin
                r_bcnt  <= '0;
                r_blink <= !r_blink;
            end else begin
                r_bcnt <= r_bcnt + 1'b1;
            end
        end
    end

    assign blink     = r_blink;
    assign disp_hour = r_hour;
    assign disp_min  = r_min;
    assign disp_sec  = r_sec;
    assign load_hour = r_hour;
    assign load_min  = r_min;
    assign load_sec  = r_sec;

endmodule
